crack_disp_ctrl: RTL and testbench

- Downstream controller for the `crack` key-search engine.
- Detects a user start request, pulses `crack` `en` through the `rdy`/`en` handshake, and waits for the search to finish.
- Latches `key`/`key_valid` and drives six active-low seven-segment displays with the result.
- Sits between the board pushbutton/HEX pins and `crack` in the top level.

---
 rtl/crack_disp_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_crack_disp_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/crack_disp_ctrl.sv
// Downstream controller for the crack key-search engine: launches a search on a
// start edge, waits for the result and shows it on six active-low HEX digits.
module crack_disp_ctrl #(
  parameter int SPIN_DIV    = 25_000_000,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        crk_en,
  input  logic        crk_rdy,
  input  logic [23:0] crk_key,
  input  logic        crk_key_valid,
  output logic        busy,
  output logic        done,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);

  localparam int SPIN_W = $clog2(SPIN_DIV + 1);
  localparam int TO_W   = $clog2(ACK_TIMEOUT + 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    ACK    = 3'd2,
    SEARCH = 3'd3,
    SHOW   = 3'd4,
    ERR    = 3'd5
  } state_t;

  state_t            state_r;
  logic              start_q_r;
  logic              arm_r;
  logic              crk_en_r;
  logic              busy_r;
  logic              done_r;
  logic [23:0]       key_r;
  logic              valid_r;
  logic [SPIN_W-1:0] spin_cnt_r;
  logic [2:0]        spin_pos_r;
  logic [TO_W-1:0]   to_cnt_r;
  logic [6:0]        hex_r [6];
  logic              start_edge_s;

  function automatic logic [6:0] hex_font(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  function automatic logic [6:0] spin_seg(input logic [2:0] pos);
    logic [6:0] seg;
    case (pos)
      3'd0:    seg = 7'b1111110;
      3'd1:    seg = 7'b1111101;
      3'd2:    seg = 7'b1111011;
      3'd3:    seg = 7'b1110111;
      3'd4:    seg = 7'b1101111;
      3'd5:    seg = 7'b1011111;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // arm_r stays low until start has been seen low, so a level held through reset never launches
  assign start_edge_s = start & ~start_q_r & arm_r;

  // Handshake sequencer with its registered status outputs, spinner and ack timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      start_q_r  <= 1'b0;
      arm_r      <= 1'b0;
      crk_en_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      key_r      <= 24'h000000;
      valid_r    <= 1'b0;
      spin_cnt_r <= {SPIN_W{1'b0}};
      spin_pos_r <= 3'd0;
      to_cnt_r   <= {TO_W{1'b0}};
    end else begin
      start_q_r <= start;
      if (!start) begin
        arm_r <= 1'b1;
      end
      crk_en_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_edge_s) begin
            state_r <= LAUNCH;
            busy_r  <= 1'b1;
          end
        end
        LAUNCH: begin
          if (crk_rdy) begin
            crk_en_r <= 1'b1;
            state_r  <= ACK;
            to_cnt_r <= {TO_W{1'b0}};
          end
        end
        ACK: begin
          if (!crk_rdy) begin
            state_r    <= SEARCH;
            spin_cnt_r <= {SPIN_W{1'b0}};
            spin_pos_r <= 3'd0;
          end else if (to_cnt_r == TO_W'(ACK_TIMEOUT - 1)) begin
            state_r <= ERR;
            busy_r  <= 1'b0;
          end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
          end
        end
        SEARCH: begin
          if (spin_cnt_r == SPIN_W'(SPIN_DIV - 1)) begin
            spin_cnt_r <= {SPIN_W{1'b0}};
            spin_pos_r <= (spin_pos_r == 3'd5) ? 3'd0 : spin_pos_r + 3'd1;
          end else begin
            spin_cnt_r <= spin_cnt_r + SPIN_W'(1);
          end
          if (crk_rdy) begin
            key_r   <= crk_key;
            valid_r <= crk_key_valid;
            state_r <= SHOW;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        SHOW, ERR: begin
          if (start_edge_s) begin
            state_r <= LAUNCH;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Display registers follow the current state; LAUNCH/ACK keep whatever was last shown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) begin
        hex_r[i] <= SEG_BLANK;
      end
    end else begin
      case (state_r)
        IDLE: begin
          for (int i = 0; i < 6; i++) begin
            hex_r[i] <= SEG_BLANK;
          end
        end
        SEARCH: begin
          hex_r[0] <= spin_seg(spin_pos_r);
          for (int i = 1; i < 6; i++) begin
            hex_r[i] <= SEG_BLANK;
          end
        end
        SHOW: begin
          for (int i = 0; i < 6; i++) begin
            hex_r[i] <= valid_r ? hex_font(key_r[4*i +: 4]) : SEG_DASH;
          end
        end
        ERR: begin
          hex_r[0] <= SEG_E;
          for (int i = 1; i < 6; i++) begin
            hex_r[i] <= SEG_BLANK;
          end
        end
        LAUNCH, ACK: begin
        end
        default: begin
          for (int i = 0; i < 6; i++) begin
            hex_r[i] <= SEG_BLANK;
          end
        end
      endcase
    end
  end

  assign crk_en = crk_en_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign hex0   = hex_r[0];
  assign hex1   = hex_r[1];
  assign hex2   = hex_r[2];
  assign hex3   = hex_r[3];
  assign hex4   = hex_r[4];
  assign hex5   = hex_r[5];

endmodule

// File: tb/tb_crack_disp_ctrl.sv
// Self-checking bench for crack_disp_ctrl: a behavioural reference model checked
// every cycle, plus directed scenarios with hand-computed display values.
module tb_crack_disp_ctrl;

  localparam int SPIN_DIV    = 4;
  localparam int ACK_TIMEOUT = 16;

  localparam int M_IDLE   = 0;
  localparam int M_LAUNCH = 1;
  localparam int M_ACK    = 2;
  localparam int M_SEARCH = 3;
  localparam int M_SHOW   = 4;
  localparam int M_ERR    = 5;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        crk_en;
  logic        crk_rdy;
  logic [23:0] crk_key;
  logic        crk_key_valid;
  logic        busy;
  logic        done;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

  int n_checks = 0;
  int n_fail   = 0;
  int en_count = 0;

  // reference model state
  int          m_state;
  int          m_sc;
  int          m_ack;
  logic        m_prev;
  logic        m_seen_low;
  logic        m_edge;
  logic        m_en;
  logic [23:0] m_key;
  logic        m_valid;
  logic [6:0]  m_hex [6];

  crack_disp_ctrl #(.SPIN_DIV(SPIN_DIV), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .crk_en(crk_en), .crk_rdy(crk_rdy),
    .crk_key(crk_key), .crk_key_valid(crk_key_valid), .busy(busy), .done(done),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] font(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[n];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // behavioural model: displays reflect the state held before each edge
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_state = M_IDLE; m_sc = 0; m_ack = 0; m_prev = 1'b0; m_seen_low = 1'b0;
      m_en = 1'b0; m_key = 24'h0; m_valid = 1'b0;
      for (int i = 0; i < 6; i++) m_hex[i] = 7'h7F;
    end else begin
      m_edge = start && !m_prev && m_seen_low;
      if (m_state == M_IDLE) begin
        for (int i = 0; i < 6; i++) m_hex[i] = 7'h7F;
      end else if (m_state == M_SEARCH) begin
        m_hex[0] = 7'h7F & ~(7'd1 << ((m_sc / SPIN_DIV) % 6));
        for (int i = 1; i < 6; i++) m_hex[i] = 7'h7F;
      end else if (m_state == M_SHOW) begin
        for (int i = 0; i < 6; i++) m_hex[i] = m_valid ? font(m_key[4*i +: 4]) : 7'b0111111;
      end else if (m_state == M_ERR) begin
        m_hex[0] = 7'b0000110;
        for (int i = 1; i < 6; i++) m_hex[i] = 7'h7F;
      end
      m_en = 1'b0;
      case (m_state)
        M_IDLE, M_SHOW, M_ERR: if (m_edge) m_state = M_LAUNCH;
        M_LAUNCH: if (crk_rdy) begin m_en = 1'b1; m_state = M_ACK; m_ack = 0; end
        M_ACK: begin
          if (!crk_rdy) begin m_state = M_SEARCH; m_sc = 0; end
          else begin
            m_ack = m_ack + 1;
            if (m_ack >= ACK_TIMEOUT) m_state = M_ERR;
          end
        end
        M_SEARCH: begin
          m_sc = m_sc + 1;
          if (crk_rdy) begin m_key = crk_key; m_valid = crk_key_valid; m_state = M_SHOW; end
        end
        default: m_state = M_IDLE;
      endcase
      m_prev = start;
      if (!start) m_seen_low = 1'b1;
    end
  end

  // per-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    if (crk_en === 1'b1) en_count++;
    check("crk_en", {31'd0, crk_en}, {31'd0, m_en});
    check("busy", {31'd0, busy}, {31'd0, (m_state >= M_LAUNCH && m_state <= M_SEARCH)});
    check("done", {31'd0, done}, {31'd0, (m_state == M_SHOW)});
    check("hex0", {25'd0, hex0}, {25'd0, m_hex[0]});
    check("hex1", {25'd0, hex1}, {25'd0, m_hex[1]});
    check("hex2", {25'd0, hex2}, {25'd0, m_hex[2]});
    check("hex3", {25'd0, hex3}, {25'd0, m_hex[3]});
    check("hex4", {25'd0, hex4}, {25'd0, m_hex[4]});
    check("hex5", {25'd0, hex5}, {25'd0, m_hex[5]});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick();
    start = 1'b0; tick();
  endtask

  task automatic wait_en();
    bit seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (crk_en) begin seen = 1'b1; break; end
      tick();
    end
    check("crk_en_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic search_flow(input logic [23:0] key, input logic valid, input int len);
    int base;
    base = en_count;
    pulse_start();
    wait_en();
    tick(); crk_rdy = 1'b0;
    repeat (len) tick();
    crk_key = key; crk_key_valid = valid; crk_rdy = 1'b1;
    repeat (3) tick();
    check("one_pulse", en_count - base, 32'd1);
    check("done_after", {31'd0, done}, 32'd1);
    check("busy_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [6:0] seq [$];
    logic [6:0] exp_seq [7];
    int base;
    rst_n = 1'b0; start = 1'b1; crk_rdy = 1'b1; crk_key = 24'h0; crk_key_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("held_start_no_pulse", en_count, 32'd0);
    check("reset_hex0", {25'd0, hex0}, 32'h7F);
    check("reset_hex5", {25'd0, hex5}, 32'h7F);
    start = 1'b0; tick();

    // valid result 1E4600
    search_flow(24'h1E4600, 1'b1, 100);
    check("k_hex5", {25'd0, hex5}, {25'd0, 7'b1111001});
    check("k_hex4", {25'd0, hex4}, {25'd0, 7'b0000110});
    check("k_hex3", {25'd0, hex3}, {25'd0, 7'b0011001});
    check("k_hex2", {25'd0, hex2}, {25'd0, 7'b0000010});
    check("k_hex1", {25'd0, hex1}, {25'd0, 7'b1000000});
    check("k_hex0", {25'd0, hex0}, {25'd0, 7'b1000000});

    // invalid result shows dashes
    search_flow(24'hFFFFFF, 1'b0, 30);
    check("dash_hex0", {25'd0, hex0}, {25'd0, 7'b0111111});
    check("dash_hex3", {25'd0, hex3}, {25'd0, 7'b0111111});
    check("dash_hex5", {25'd0, hex5}, {25'd0, 7'b0111111});

    // rdy low at launch, extra start edges during search
    base = en_count;
    crk_rdy = 1'b0;
    pulse_start();
    repeat (20) tick();
    check("no_pulse_while_unready", en_count - base, 32'd0);
    crk_rdy = 1'b1;
    wait_en();
    tick(); crk_rdy = 1'b0;
    repeat (5) tick();
    pulse_start(); pulse_start();
    repeat (10) tick();
    crk_key = 24'hABCDEF; crk_key_valid = 1'b1; crk_rdy = 1'b1;
    repeat (3) tick();
    check("single_pulse_search", en_count - base, 32'd1);
    check("abc_hex5", {25'd0, hex5}, {25'd0, 7'b0001000});
    check("abc_hex0", {25'd0, hex0}, {25'd0, 7'b0001110});

    // ack timeout: rdy never drops
    pulse_start();
    wait_en();
    repeat (20) tick();
    check("err_hex0", {25'd0, hex0}, {25'd0, 7'b0000110});
    check("err_busy", {31'd0, busy}, 32'd0);
    check("err_done", {31'd0, done}, 32'd0);

    // relaunch from error, then watch the spinner
    base = en_count;
    pulse_start();
    wait_en();
    tick(); crk_rdy = 1'b0;
    for (int i = 0; i < 34; i++) begin
      tick();
      if (hex0 != 7'b0000110 && (seq.size() == 0 || seq[$] != hex0)) seq.push_back(hex0);
    end
    check("relaunch_pulse", en_count - base, 32'd1);
    exp_seq = '{7'b1111110, 7'b1111101, 7'b1111011, 7'b1110111, 7'b1101111, 7'b1011111, 7'b1111110};
    check("spin_steps", (seq.size() >= 7) ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < 7 && i < seq.size(); i++)
      check($sformatf("spin%0d", i), {25'd0, seq[i]}, {25'd0, exp_seq[i]});

    // asynchronous reset mid-search
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check("arst_hex0", {25'd0, hex0}, 32'h7F);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_en", {31'd0, crk_en}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("post_reset_idle_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
